// File: rtl/lsu.sv
// Load/store unit: turns an ALU effective address plus rs2 data into a single
// request/acknowledge transaction to data memory and returns extended load data.
// The core is stalled from acceptance until the transaction leaves REQ.
module lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_stall,
  output logic [31:0] o_ld_data,
  output logic        o_ld_valid,
  output logic        o_exc,
  output logic        o_bus_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        load_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_bmask_q;
  logic [31:0] ld_data_q;
  logic        ld_valid_q;
  logic        bus_err_q;

  logic        legal;
  logic [31:0] wdata_d;
  logic [3:0]  bmask_d;

  // Decode access legality (alignment and funct3) for the presented instruction.
  always_comb begin
    legal = 1'b0;
    if (i_we) begin
      unique case (i_funct3)
        3'b000:  legal = 1'b1;
        3'b001:  legal = ~i_addr[0];
        3'b010:  legal = (i_addr[1:0] == 2'b00);
        default: legal = 1'b0;
      endcase
    end else begin
      unique case (i_funct3)
        3'b000, 3'b100: legal = 1'b1;
        3'b001, 3'b101: legal = ~i_addr[0];
        3'b010:         legal = (i_addr[1:0] == 2'b00);
        default:        legal = 1'b0;
      endcase
    end
  end

  // Replicate store data across lanes and build the byte mask; loads read the full word.
  always_comb begin
    wdata_d = '0;
    bmask_d = 4'b1111;
    if (i_we) begin
      unique case (i_funct3[1:0])
        2'b00: begin
          wdata_d = {4{i_st_data[7:0]}};
          bmask_d = 4'b0001 << i_addr[1:0];
        end
        2'b01: begin
          wdata_d = {2{i_st_data[15:0]}};
          bmask_d = 4'b0011 << i_addr[1:0];
        end
        default: begin
          wdata_d = i_st_data;
          bmask_d = 4'b1111;
        end
      endcase
    end
  end

  // Select the addressed byte/half of the returned word and extend it.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    unique case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  // Transaction FSM; all memory-side and result outputs are registered here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      funct3_q    <= '0;
      off_q       <= '0;
      load_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_bmask_q <= '0;
      ld_data_q   <= '0;
      ld_valid_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid && legal) begin
            state_q     <= StReq;
            cnt_q       <= '0;
            funct3_q    <= i_funct3;
            off_q       <= i_addr[1:0];
            load_q      <= ~i_we;
            mem_req_q   <= 1'b1;
            mem_we_q    <= i_we;
            mem_addr_q  <= {i_addr[31:2], 2'b00};
            mem_wdata_q <= wdata_d;
            mem_bmask_q <= bmask_d;
          end
        end
        StReq: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (i_mem_ack || cnt_q == CntLast) begin
            state_q     <= StDone;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_bmask_q <= '0;
            bus_err_q   <= ~i_mem_ack;
            ld_valid_q  <= i_mem_ack & load_q;
            ld_data_q   <= (i_mem_ack && load_q) ? extract(i_mem_rdata, funct3_q, off_q) : '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          state_q    <= StIdle;
          ld_valid_q <= 1'b0;
          bus_err_q  <= 1'b0;
          ld_data_q  <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_stall     = ((state_q == StIdle) && i_valid && legal) || (state_q == StReq);
  assign o_exc       = (state_q == StIdle) && i_valid && !legal;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_bmask = mem_bmask_q;
  assign o_ld_data   = ld_data_q;
  assign o_ld_valid  = ld_valid_q;
  assign o_bus_err   = bus_err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: expected results are queued when an access is driven
// and popped when the DONE cycle is observed.
module tb_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        we;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] sd;
  logic        ack;
  logic [31:0] rdata;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        exc;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bmask;

  typedef struct {
    logic [31:0] data;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(TO)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (valid),
    .i_we        (we),
    .i_funct3    (f3),
    .i_addr      (addr),
    .i_st_data   (sd),
    .o_stall     (stall),
    .o_ld_data   (ld_data),
    .o_ld_valid  (ld_valid),
    .o_exc       (exc),
    .o_bus_err   (bus_err),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_bmask (mem_bmask),
    .i_mem_ack   (ack),
    .i_mem_rdata (rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete access; ack_at is the REQ cycle (1-based) carrying ack, 0 = never.
  task automatic run_access(input string tag, input logic we_i, input logic [2:0] f3_i,
                            input logic [31:0] a, input logic [31:0] sd_i, input int ack_at,
                            input logic [31:0] rd, input logic [31:0] exp_maddr,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_bmask,
                            input logic [31:0] exp_ld, input logic exp_v, input logic exp_err);
    int   nreq;
    exp_t e;
    valid = 1'b1;
    we    = we_i;
    f3    = f3_i;
    addr  = a;
    sd    = sd_i;
    ack   = 1'b0;
    sb.push_back('{exp_ld, exp_v, exp_err});
    #1;
    check({tag, " accept stall"}, 32'(stall), 32'd1);
    check({tag, " accept exc"}, 32'(exc), 32'd0);
    nreq = (ack_at >= 1 && ack_at <= TO) ? ack_at : TO;
    for (int k = 1; k <= nreq; k++) begin
      @(posedge clk);
      #1;
      ack   = (k == ack_at);
      rdata = ack ? rd : $urandom;
      #1;
      check({tag, " req"}, 32'(mem_req), 32'd1);
      check({tag, " req stall"}, 32'(stall), 32'd1);
      if (k == 1 || k == nreq) begin
        check({tag, " mem_addr"}, mem_addr, exp_maddr);
        check({tag, " mem_wdata"}, mem_wdata, exp_wdata);
        check({tag, " mem_bmask"}, 32'(mem_bmask), 32'(exp_bmask));
        check({tag, " mem_we"}, 32'(mem_we), 32'(we_i));
      end
    end
    @(posedge clk);
    #1;
    ack   = 1'b0;
    rdata = $urandom;
    #1;
    check({tag, " scoreboard depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " ld_data"}, ld_data, e.data);
      check({tag, " ld_valid"}, 32'(ld_valid), 32'(e.valid));
      check({tag, " bus_err"}, 32'(bus_err), 32'(e.err));
    end
    check({tag, " done stall"}, 32'(stall), 32'd0);
    check({tag, " done req"}, 32'(mem_req), 32'd0);
    @(posedge clk);
    #1;
    valid = 1'b0;
    #1;
    check({tag, " idle ld_valid"}, 32'(ld_valid), 32'd0);
    check({tag, " idle stall"}, 32'(stall), 32'd0);
  endtask

  task automatic exc_access(input string tag, input logic we_i, input logic [2:0] f3_i,
                            input logic [31:0] a);
    valid = 1'b1;
    we    = we_i;
    f3    = f3_i;
    addr  = a;
    sd    = 32'hCAFE_F00D;
    #1;
    check({tag, " exc"}, 32'(exc), 32'd1);
    check({tag, " stall"}, 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    valid = 1'b0;
    #1;
    check({tag, " no req"}, 32'(mem_req), 32'd0);
    check({tag, " exc cleared"}, 32'(exc), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    we    = 1'b0;
    f3    = 3'b000;
    addr  = '0;
    sd    = '0;
    ack   = 1'b0;
    rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req", 32'(mem_req), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset bmask", 32'(mem_bmask), 32'd0);
    check("reset ld_data", ld_data, 32'd0);
    check("reset flags", {29'd0, ld_valid, bus_err, stall}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_access("LW", 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEAD_BEEF,
               32'h100, 32'h0, 4'b1111, 32'hDEAD_BEEF, 1'b1, 1'b0);
    run_access("LB", 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_0000,
               32'h100, 32'h0, 4'b1111, 32'hFFFF_FF80, 1'b1, 1'b0);
    run_access("LBU", 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_0000,
               32'h100, 32'h0, 4'b1111, 32'h0000_0080, 1'b1, 1'b0);
    run_access("LHU", 1'b0, 3'b101, 32'h102, 32'h0, 3, 32'h80FF_0000,
               32'h100, 32'h0, 4'b1111, 32'h0000_80FF, 1'b1, 1'b0);
    run_access("LH", 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80FF_0000,
               32'h100, 32'h0, 4'b1111, 32'hFFFF_80FF, 1'b1, 1'b0);
    run_access("LB0", 1'b0, 3'b000, 32'h240, 32'h0, 1, 32'h1234_5678,
               32'h240, 32'h0, 4'b1111, 32'h0000_0078, 1'b1, 1'b0);
    run_access("SH", 1'b1, 3'b001, 32'h6, 32'h1234_ABCD, 1, 32'h0,
               32'h4, 32'hABCD_ABCD, 4'b1100, 32'h0, 1'b0, 1'b0);
    run_access("SB", 1'b1, 3'b000, 32'h101, 32'h0000_00A5, 2, 32'h0,
               32'h100, 32'hA5A5_A5A5, 4'b0010, 32'h0, 1'b0, 1'b0);
    run_access("SW", 1'b1, 3'b010, 32'h200, 32'h1122_3344, 1, 32'h0,
               32'h200, 32'h1122_3344, 4'b1111, 32'h0, 1'b0, 1'b0);
    run_access("LW timeout", 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'h0,
               32'h100, 32'h0, 4'b1111, 32'h0, 1'b0, 1'b1);
    run_access("LW last ack", 1'b0, 3'b010, 32'h100, 32'h0, TO, 32'h5555_AAAA,
               32'h100, 32'h0, 4'b1111, 32'h5555_AAAA, 1'b1, 1'b0);
    run_access("SW timeout", 1'b1, 3'b010, 32'h80, 32'h0F0F_0F0F, 0, 32'h0,
               32'h80, 32'h0F0F_0F0F, 4'b1111, 32'h0, 1'b0, 1'b1);

    exc_access("LW misaligned", 1'b0, 3'b010, 32'h102);
    exc_access("LH odd", 1'b0, 3'b001, 32'h101);
    exc_access("load f3 110", 1'b0, 3'b110, 32'h100);
    exc_access("store f3 011", 1'b1, 3'b011, 32'h100);

    // Reset while in REQ, then a late ack that must be ignored.
    valid = 1'b1;
    we    = 1'b0;
    f3    = 3'b010;
    addr  = 32'h300;
    @(posedge clk);
    #1;
    check("rst-mid req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    valid = 1'b0;
    ack   = 1'b1;
    rdata = 32'hFFFF_FFFF;
    #1;
    check("rst-mid req dropped", 32'(mem_req), 32'd0);
    check("rst-mid stall", 32'(stall), 32'd0);
    check("rst-mid ld_valid", 32'(ld_valid), 32'd0);
    @(posedge clk);
    #1;
    ack = 1'b0;
    #1;
    check("late ack ld_valid", 32'(ld_valid), 32'd0);
    check("late ack req", 32'(mem_req), 32'd0);
    check("late ack bus_err", 32'(bus_err), 32'd0);
    check("late ack ld_data", ld_data, 32'd0);

    run_access("LW after rst", 1'b0, 3'b010, 32'h104, 32'h0, 1, 32'h0BAD_F00D,
               32'h104, 32'h0, 4'b1111, 32'h0BAD_F00D, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute bound so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit directly downstream of the ALU in the RV32I datapath. Takes the ALU result as effective address plus rs2 store data, runs a request/acknowledge transaction to data memory, and returns aligned, sign- or zero-extended load data for write-back. While a transaction is outstanding it holds `o_stall` high so the core freezes PC and register-file writes.

## Interface
- `TIMEOUT`, default 16: REQ cycles without `i_mem_ack` before bus error; legal range 2..255.
- `i_clk` in 1: core clock; all state changes on rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_valid` in 1: current instruction is a load or store; fields below are valid.
- `i_we` in 1: 1 = store, 0 = load.
- `i_funct3` in 3: RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `i_addr` in 32: effective address (ALU `o_alu_data`).
- `i_st_data` in 32: rs2 data.
- `o_stall` out 1: core must hold the current instruction.
- `o_ld_data` out 32: extended load result, valid when `o_ld_valid`.
- `o_ld_valid` out 1: load result valid this cycle (write-back enable).
- `o_exc` out 1: misaligned address or illegal funct3.
- `o_bus_err` out 1: memory did not acknowledge within `TIMEOUT`.
- `o_mem_req` out 1: memory request.
- `o_mem_we` out 1: request is a write.
- `o_mem_addr` out 32: word address, `{i_addr[31:2], 2'b00}`.
- `o_mem_wdata` out 32: lane-replicated store data.
- `o_mem_bmask` out 4: byte-enable mask.
- `i_mem_ack` in 1: memory completes the request this cycle.
- `i_mem_rdata` in 32: read word, valid with `i_mem_ack`.

## Operation
- FSM states: IDLE, REQ, DONE. Reset state IDLE.
- IDLE: if `i_valid` and access legal, capture we, funct3, addr[1:0], mem fields into registers, go to REQ. If `i_valid` and illegal, assert `o_exc` (combinational, this cycle only), stay IDLE, no memory access.
- Illegal: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0; load funct3 011/110/111; store funct3 ≥011.
- REQ: `o_mem_req`=1 with registered fields. On `i_mem_ack`: capture `i_mem_rdata` (loads), go to DONE. Timeout counter increments each REQ cycle without ack; when it reaches `TIMEOUT`-1 without ack, drop request, set bus-error flag, go to DONE.
- DONE: one cycle. `o_ld_valid`=1 for a load without bus error; `o_bus_err`=1 if flagged; `o_ld_data` driven. `i_valid` ignored (same instruction still presented). Next state IDLE.
- Store lanes: SB wdata = 4× byte, bmask = 0001 << addr[1:0]; SH wdata = 2× half, bmask = 0011 << addr[1:0]; SW wdata = data, bmask 1111. Loads drive bmask 1111, wdata 0.
- Load extraction: byte/half selected by captured addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through. On bus error `o_ld_data`=0.
- `o_stall` = (IDLE & `i_valid` & legal) | REQ. Low in DONE and on `o_exc`.

## Timing
- Reset: state IDLE, counter 0, all outputs 0 (`o_mem_*` 0, `o_ld_data` 0, flags 0).
- Minimum latency: accept at cycle N, `o_mem_req` at N+1, ack at N+1, DONE at N+2; stall high N..N+1.
- Ack may arrive in the first REQ cycle; request fields stable throughout REQ.
- Ack in IDLE or DONE is ignored.
- Ack in the same cycle the counter reaches `TIMEOUT`-1: ack wins, no bus error.
- `i_rst` in any state: next cycle IDLE, `o_mem_req` dropped, captured data discarded; no DONE pulse.
- Back-to-back accesses: new `i_valid` accepted in the IDLE cycle after DONE (one bubble).

## Test plan
- LW addr 0x100, ack 2 cycles after req, rdata 0xDEADBEEF -> stall 3 cycles, DONE `o_ld_data`=0xDEADBEEF, `o_ld_valid`=1.
- LB addr 0x103, rdata 0x80FF_0000 -> `o_ld_data`=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
- SH addr 0x0006, data 0x1234ABCD -> `o_mem_addr`=0x4, wdata 0xABCDABCD, bmask 1100, `o_mem_we`=1, `o_ld_valid` stays 0.
- LW addr 0x102 -> `o_exc`=1 one cycle, `o_stall`=0, `o_mem_req` never asserted.
- TIMEOUT=4, no ack -> req high 4 cycles, DONE `o_bus_err`=1, `o_ld_data`=0; repeat with ack on 4th REQ cycle -> no bus error.
- Assert `i_rst` during REQ -> next cycle `o_mem_req`=0, IDLE, no `o_ld_valid`; late ack ignored.
